// File: rtl/xbox_xlr_vec_reduce_if.sv
// Memory-side and host-side signal bundle of the XLR vector reducer.
// master = the accelerator, slave = the memory/host environment.
interface xbox_xlr_vec_reduce_if #(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int DATA_W             = 256,
    parameter int NUM_GPP            = 8,
    parameter int GPP_W              = 32
) ();
    logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr;
    logic [NUM_MEMS-1:0][DATA_W-1:0]             xlr_mem_wdata;
    logic [NUM_MEMS-1:0][DATA_W/8-1:0]           xlr_mem_be;
    logic [NUM_MEMS-1:0]                         xlr_mem_rd;
    logic [NUM_MEMS-1:0]                         xlr_mem_wr;
    logic [NUM_MEMS-1:0][DATA_W-1:0]             xlr_mem_rdata;
    logic [NUM_GPP-1:0][GPP_W-1:0]               host_regs;
    logic                                        host_regs_valid_pulse;
    logic [NUM_GPP-1:0][GPP_W-1:0]               host_regs_data_out;
    logic                                        host_regs_valid_out;

    modport master (
        output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
        output host_regs_data_out, host_regs_valid_out,
        input  xlr_mem_rdata, host_regs, host_regs_valid_pulse
    );

    modport slave (
        input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
        input  host_regs_data_out, host_regs_valid_out,
        output xlr_mem_rdata, host_regs, host_regs_valid_pulse
    );
endinterface

// File: rtl/xbox_xlr_vec_reduce.sv
// XLR vector reducer: line-wise add/xor/max over all memories into mem 0, two cycles per line.
// Optional cycle counter on data_out[2] enabled by defining XLR_PERF_CNT_EN.
module xbox_xlr_vec_reduce #(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int DATA_W             = 256,
    parameter int LANE_W             = 32,
    parameter int NUM_GPP            = 8,
    parameter int GPP_W              = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    xbox_xlr_vec_reduce_if.master bus
);
    localparam int AW    = LOG2_LINES_PER_MEM;
    localparam int LANES = DATA_W / LANE_W;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t                            state_q;
    logic [AW-1:0]                     src_q, dst_q;
    logic [AW:0]                       len_q, idx_q, lines_q;
    logic [1:0]                        mode_q;
    logic [3:0]                        status_q;
    logic [NUM_MEMS-1:0][AW-1:0]       addr_q;
    logic [NUM_MEMS-1:0]               rd_q, wr_q;
    logic [NUM_MEMS-1:0][BE_W-1:0]     be_q;
    logic                              valid_q;

    logic [AW:0]                       len_sat;
    logic                              bad_mode;
    logic [AW:0]                       dst_sum, src_next;
    logic [GPP_W-1:0]                  cycles_out;
    logic [NUM_MEMS-1:0][DATA_W-1:0]   wdata;
    logic [NUM_GPP-1:0][GPP_W-1:0]     data_out;
    logic                              unused_host;

    // Carry bit of the result marks a wrap past the last line.
    function automatic logic [AW:0] line_add(input logic [AW-1:0] base, input logic [AW:0] off);
        return {1'b0, base} + off;
    endfunction

    function automatic logic [DATA_W-1:0] reduce_lines(
        input logic [NUM_MEMS-1:0][DATA_W-1:0] lines,
        input logic [1:0]                      mode
    );
        logic [DATA_W-1:0] acc;
        logic [LANE_W-1:0] a, b;
        acc = lines[0];
        for (int m = 1; m < NUM_MEMS; m++) begin
            for (int l = 0; l < LANES; l++) begin
                a = acc[l*LANE_W +: LANE_W];
                b = lines[m][l*LANE_W +: LANE_W];
                case (mode)
                    2'd0:    acc[l*LANE_W +: LANE_W] = a + b;
                    2'd1:    acc[l*LANE_W +: LANE_W] = a ^ b;
                    default: acc[l*LANE_W +: LANE_W] = (a > b) ? a : b;
                endcase
            end
        end
        return acc;
    endfunction

    assign len_sat     = (bus.host_regs[2] > GPP_W'(MAX_LEN)) ? MAX_LEN : bus.host_regs[2][AW:0];
    assign bad_mode    = (bus.host_regs[3][1:0] == 2'd3);
    assign dst_sum     = line_add(dst_q, idx_q);
    assign src_next    = line_add(src_q, idx_q + 1'b1);
    assign unused_host = ^bus.host_regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            lines_q  <= '0;
            mode_q   <= '0;
            status_q <= '0;
            addr_q   <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            be_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_q    <= '0;
            wr_q    <= '0;
            be_q    <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            if (bus.host_regs_valid_pulse && state_q != IDLE) status_q[1] <= 1'b1;
            case (state_q)
                IDLE: if (bus.host_regs_valid_pulse) begin
                    src_q   <= bus.host_regs[0][AW-1:0];
                    dst_q   <= bus.host_regs[1][AW-1:0];
                    len_q   <= len_sat;
                    mode_q  <= bus.host_regs[3][1:0];
                    idx_q   <= '0;
                    lines_q <= '0;
                    if (len_sat == '0 || bad_mode) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        status_q <= {bad_mode, 3'b001};
                    end else begin
                        state_q  <= RD;
                        status_q <= '0;
                        rd_q     <= '1;
                        for (int m = 0; m < NUM_MEMS; m++) addr_q[m] <= bus.host_regs[0][AW-1:0];
                    end
                end
                RD: begin
                    state_q   <= WR;
                    wr_q[0]   <= 1'b1;
                    be_q[0]   <= '1;
                    addr_q[0] <= dst_sum[AW-1:0];
                    if (dst_sum[AW]) status_q[2] <= 1'b1;
                end
                WR: begin
                    lines_q <= lines_q + 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        state_q     <= DONE;
                        valid_q     <= 1'b1;
                        status_q[0] <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= RD;
                        rd_q    <= '1;
                        for (int m = 0; m < NUM_MEMS; m++) addr_q[m] <= src_next[AW-1:0];
                        if (src_next[AW]) status_q[2] <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef XLR_PERF_CNT_EN
    logic [GPP_W-1:0] cycles_q, cycles_d;

    // Counts the accept cycle plus every RD/WR cycle, saturating.
    always_comb begin
        cycles_d = cycles_q;
        if (state_q == IDLE && bus.host_regs_valid_pulse)
            cycles_d = GPP_W'(1);
        else if ((state_q == RD || state_q == WR) && cycles_q != '1)
            cycles_d = cycles_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycles_q <= '0;
        else        cycles_q <= cycles_d;
    end

    assign cycles_out = cycles_q;
`else
    assign cycles_out = '0;
`endif

    // Read data arrives during WR, so the write line is reduced combinationally.
    always_comb begin
        wdata = '0;
        if (state_q == WR) wdata[0] = reduce_lines(bus.xlr_mem_rdata, mode_q);
    end

    always_comb begin
        data_out    = '0;
        data_out[0] = GPP_W'(status_q);
        data_out[1] = GPP_W'(lines_q);
        data_out[2] = cycles_out;
    end

    assign bus.xlr_mem_addr        = addr_q;
    assign bus.xlr_mem_wdata       = wdata;
    assign bus.xlr_mem_be          = be_q;
    assign bus.xlr_mem_rd          = rd_q;
    assign bus.xlr_mem_wr          = wr_q;
    assign bus.host_regs_data_out  = data_out;
    assign bus.host_regs_valid_out = valid_q;
endmodule
